pie_encoder: RTL
================

# pie_encoder

Reader-to-tag transmit encoder for the RFID reader datapath; it is the downlink counterpart of the uplink preamble detection and decoding chain. It accepts a stream of command bits over a valid/ready handshake and produces the baseband modulation envelope `tx_out`. Each frame is a delimiter, then a preamble (data-0, RTcal, TRcal) or frame-sync (data-0, RTcal), then the PIE-encoded bits. It sits between the command formatter and the DAC/modulator drive logic.

## Interface

**Parameters**
- `TARI_CYCLES`, 8: data-0 symbol length in clk cycles.
- `DATA1_CYCLES`, 14: data-1 symbol length; must satisfy TARI_CYCLES < DATA1_CYCLES <= 2*TARI_CYCLES.
- `PW_CYCLES`, 4: low pulse width at the end of every symbol; must be < TARI_CYCLES.
- `DELIM_CYCLES`, 6: delimiter low time.
- `TRCAL_CYCLES`, 30: TRcal length; must be > PW_CYCLES.
- RTcal length is the localparam TARI_CYCLES+DATA1_CYCLES.
- The counter width is $clog2 of the largest symbol length plus 1.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin frame; honoured only in IDLE.
- `preamble_sel` in 1: sampled with start; 1 selects full preamble (with TRcal), 0 selects frame-sync.
- `in_dat` in 1: command bit.
- `in_vld` in 1: in_dat valid.
- `in_last` in 1: marks the final bit of the frame.
- `in_rdy` out 1: holding register empty.
- `tx_out` out 1: envelope; 1 = carrier high, 0 = modulated low. Registered.
- `busy` out 1: frame in progress. Registered.
- `done` out 1: one-cycle pulse at frame completion. Registered.
- `underrun` out 1: one-cycle pulse when a frame is aborted. Registered.

## Operation

- **Holding register (1 entry: bit, last, valid).**
  - Loads when in_vld && in_rdy.
  - in_rdy = !hold_vld; there is no same-cycle load-and-consume.
  - Preloading while IDLE is allowed.
- **States:** IDLE, DELIM, SYNC0, RTCAL, TRCAL, DATA.
- **Symbol shaping.** Each non-delimiter symbol of length L drives tx_out=1 for L-PW_CYCLES cycles, then 0 for PW_CYCLES cycles. The delimiter is all low.
- **Transitions:**
  - IDLE to DELIM on start. preamble_sel is latched at this point.
  - DELIM to SYNC0 after DELIM_CYCLES.
  - SYNC0 (length TARI) to RTCAL.
  - RTCAL to TRCAL if the latched preamble_sel is 1, otherwise to DATA.
  - TRCAL to DATA.
  - DATA to DATA or IDLE, as below.
- **Bit fetch.** On the last cycle of RTcal (frame-sync) or TRcal (preamble), and on the last cycle of each data symbol whose bit had last=0:
  - If hold_vld: consume the entry (clears hold_vld) and start the next DATA symbol, of length TARI_CYCLES for 0 or DATA1_CYCLES for 1.
  - If !hold_vld: abort. Go to IDLE, tx_out=1 next cycle, underrun pulses, busy drops, done stays 0.
- **Frame end.** At the last cycle of a data symbol whose bit had last=1: go to IDLE; done pulses next cycle, busy drops and tx_out=1 next cycle.
- **start while busy:** ignored. A frame with zero bits is not possible; it underruns at the first fetch.
- **Reset (any time, including mid-frame):**
  - State IDLE, counter 0.
  - hold_vld=0, so in_rdy=1.
  - tx_out=1, busy=0, done=0, underrun=0.

## Timing

- start sampled high at cycle 0 puts tx_out low in cycles 1..DELIM_CYCLES, and busy=1 from cycle 1.
- Symbols are contiguous with no gap cycles. The first data symbol starts the cycle after the last cycle of RTcal or TRcal.
- done/underrun assert, and busy/tx_out return, in the cycle immediately after the final symbol's last low cycle.
- Upstream has at least TARI_CYCLES-1 cycles per bit to refill the holding register.

## Test plan

- **Frame-sync, 1 bit.** Defaults; bit 0 preloaded (last=1), start at cycle 0 with preamble_sel=0.
  - tx_out 0 in cycles 1–6; high 7–10, low 11–14; high 15–32, low 33–36; data-0 high 37–40, low 41–44.
  - done=1 and tx_out=1 at cycle 45; busy=0 at 45.
- **Preamble, bits 1,0 streamed.** preamble_sel=1.
  - TRcal high 37–62, low 63–66.
  - Data-1 at 67–80 (low 77–80), then data-0 at 81–88.
  - done at 89; in_rdy high again at cycle 67.
- **Underrun.** Frame-sync with one bit (last=0) and in_vld held low afterwards.
  - underrun pulses at 45, tx_out=1 at 45, done never asserts.
- **Reset mid-frame.** rst at cycle 20 (inside RTcal).
  - Cycle 21: tx_out=1, busy=0, in_rdy=1, and the holding register is empty.
  - A new start then produces a clean delimiter.
- **Start while busy.** Pulse start at cycle 10 during a frame: the waveform is unchanged and there is no extra frame.
- **Back-to-back frames.** start asserted in the same cycle done pulses is accepted; the delimiter begins the following cycle.

Source files
------------

// File: rtl/pie_encoder.sv
// PIE transmit encoder: delimiter, preamble/frame-sync, then PIE data symbols
// shaped into a registered baseband envelope. One-entry holding register
// decouples the command formatter from symbol timing.
module pie_encoder #(
  parameter int unsigned TARI_CYCLES  = 8,
  parameter int unsigned DATA1_CYCLES = 14,
  parameter int unsigned PW_CYCLES    = 4,
  parameter int unsigned DELIM_CYCLES = 6,
  parameter int unsigned TRCAL_CYCLES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic preamble_sel,
  input  logic in_dat,
  input  logic in_vld,
  input  logic in_last,
  output logic in_rdy,
  output logic tx_out,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int unsigned RTCAL_CYCLES = TARI_CYCLES + DATA1_CYCLES;
  localparam int unsigned MaxCal = (RTCAL_CYCLES > TRCAL_CYCLES) ? RTCAL_CYCLES : TRCAL_CYCLES;
  localparam int unsigned MaxLen = (MaxCal > DELIM_CYCLES) ? MaxCal : DELIM_CYCLES;
  localparam int unsigned CW     = $clog2(MaxLen) + 1;

  localparam logic [CW-1:0] LenTari  = CW'(TARI_CYCLES);
  localparam logic [CW-1:0] LenData1 = CW'(DATA1_CYCLES);
  localparam logic [CW-1:0] LenRtcal = CW'(RTCAL_CYCLES);
  localparam logic [CW-1:0] LenTrcal = CW'(TRCAL_CYCLES);
  localparam logic [CW-1:0] LenDelim = CW'(DELIM_CYCLES);
  localparam logic [CW-1:0] LenPw    = CW'(PW_CYCLES);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StDelim = 3'd1;
  localparam logic [2:0] StSync0 = 3'd2;
  localparam logic [2:0] StRtcal = 3'd3;
  localparam logic [2:0] StTrcal = 3'd4;
  localparam logic [2:0] StData  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          psel_q, psel_d;
  logic          dbit_q, dbit_d;
  logic          dlast_q, dlast_d;
  logic          hold_vld_q, hold_vld_d;
  logic          hold_bit_q, hold_bit_d;
  logic          hold_last_q, hold_last_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          underrun_q, underrun_d;

  logic [CW-1:0] cur_len, nxt_len;
  logic          last_cyc, fetch, consume;

  function automatic logic [CW-1:0] sym_len(input logic [2:0] st, input logic b);
    case (st)
      StDelim: sym_len = LenDelim;
      StSync0: sym_len = LenTari;
      StRtcal: sym_len = LenRtcal;
      StTrcal: sym_len = LenTrcal;
      StData:  sym_len = b ? LenData1 : LenTari;
      default: sym_len = LenTari;
    endcase
  endfunction

  assign in_rdy   = !hold_vld_q;
  assign tx_out   = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

  // Sequencer: symbol counter, state walk, bit fetch and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    psel_d     = psel_q;
    dbit_d     = dbit_q;
    dlast_d    = dlast_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    consume    = 1'b0;

    cur_len  = sym_len(state_q, dbit_q);
    last_cyc = (cnt_q == cur_len - 1'b1);
    // Fetch points: end of the last calibration symbol, or of a non-final data bit.
    fetch    = last_cyc && (((state_q == StRtcal) && !psel_q) || (state_q == StTrcal) ||
                            ((state_q == StData) && !dlast_q));

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          state_d = StDelim;
          psel_d  = preamble_sel;
        end
      end
      StDelim: if (last_cyc) begin state_d = StSync0; cnt_d = '0; end
      StSync0: if (last_cyc) begin state_d = StRtcal; cnt_d = '0; end
      StRtcal: if (last_cyc && psel_q) begin state_d = StTrcal; cnt_d = '0; end
      StData: if (last_cyc && dlast_q) begin
        state_d = StIdle;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
      default: ;
    endcase

    if (fetch) begin
      cnt_d = '0;
      if (hold_vld_q) begin
        state_d = StData;
        dbit_d  = hold_bit_q;
        dlast_d = hold_last_q;
        consume = 1'b1;
      end else begin
        state_d    = StIdle;
        underrun_d = 1'b1;
      end
    end

    nxt_len = sym_len(state_d, dbit_d);
    busy_d  = (state_d != StIdle);
    if (state_d == StIdle)       tx_d = 1'b1;
    else if (state_d == StDelim) tx_d = 1'b0;
    else                         tx_d = (cnt_d < nxt_len - LenPw);
  end

  // Holding register: load only when empty, so load and consume never collide.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_bit_d  = hold_bit_q;
    hold_last_d = hold_last_q;
    if (consume) hold_vld_d = 1'b0;
    if (in_vld && in_rdy) begin
      hold_vld_d  = 1'b1;
      hold_bit_d  = in_dat;
      hold_last_d = in_last;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      dbit_q      <= 1'b0;
      dlast_q     <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_bit_q  <= 1'b0;
      hold_last_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      dbit_q      <= dbit_d;
      dlast_q     <= dlast_d;
      hold_vld_q  <= hold_vld_d;
      hold_bit_q  <= hold_bit_d;
      hold_last_q <= hold_last_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule
